// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with dead-time, blanking and blinking
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] raw_segs,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         r_p;
  logic [IW-1:0]         r_idx;
  logic [FW-1:0]         r_fc;
  logic                  r_bp;
  logic [3:0]            r_nib;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_frame_tick;

  logic [3:0]            w_raw_nib;
  logic                  w_blank;
  logic                  w_blink;
  logic [NUM_DIGITS-1:0] w_an_lit;
  logic [6:0]            w_seg_dec;
  logic                  w_lit;

  // Per-digit selection done by comparison so any NUM_DIGITS (not only powers of two) is safe.
  always_comb begin
    w_raw_nib = 4'h0;
    w_blank   = 1'b0;
    w_blink   = 1'b0;
    w_an_lit  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_raw_nib   = raw_segs[4*i +: 4];
        w_blank     = blank_mask[i];
        w_blink     = blink_mask[i];
        w_an_lit[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_seg_dec = 7'h3F;
    case (r_nib)
      4'd0: w_seg_dec = 7'h40;
      4'd1: w_seg_dec = 7'h79;
      4'd2: w_seg_dec = 7'h24;
      4'd3: w_seg_dec = 7'h30;
      4'd4: w_seg_dec = 7'h19;
      4'd5: w_seg_dec = 7'h12;
      4'd6: w_seg_dec = 7'h02;
      4'd7: w_seg_dec = 7'h78;
      4'd8: w_seg_dec = 7'h00;
      4'd9: w_seg_dec = 7'h10;
      default: w_seg_dec = 7'h3F;
    endcase
  end

  // Cycle 0 of each slot is dead-time; blanking beats blinking since either forces dark.
  assign w_lit = (r_p != '0) && !w_blank && !(w_blink && r_bp);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p          <= '0;
      r_idx        <= '0;
      r_fc         <= '0;
      r_bp         <= 1'b0;
      r_nib        <= 4'h0;
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_frame_tick <= 1'b0;
      if (en) begin
        if (w_lit) begin
          r_an  <= w_an_lit;
          r_seg <= w_seg_dec;
        end
        if (r_p == '0) begin
          r_nib <= w_raw_nib;
        end
        if (r_p == P_LAST) begin
          r_p <= '0;
          if (r_idx == I_LAST) begin
            r_idx        <= '0;
            r_frame_tick <= 1'b1;
            if (r_fc == FC_LAST) begin
              r_fc <= '0;
              r_bp <= ~r_bp;
            end else begin
              r_fc <= r_fc + FW'(1);
            end
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end else begin
          r_p <= r_p + PW'(1);
        end
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BF = 2;

  typedef struct {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          ft;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [4*ND-1:0] raw_segs = '0;
  logic [ND-1:0] blank_mask = '0;
  logic [ND-1:0] blink_mask = '0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          frame_tick;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t m_x;
  logic mon_on = 1'b0;

  int         m_n = 0;
  logic [3:0] m_nib = 4'h0;
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetn(resetn), .en(en), .raw_segs(raw_segs),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Model: the n-th enabled edge since reset sits at p = n%SD of slot n/SD.
  task automatic step(input logic e, input logic rn, input logic [4*ND-1:0] raw,
                      input logic [ND-1:0] bl, input logic [ND-1:0] bk);
    exp_t x;
    int   p, slot, idx, bp;
    @(negedge clk);
    if (!rn && resetn) begin
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (an !== '1 || seg !== 7'h7F || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL async_reset: an=%b seg=%h ft=%b, want an=111111 seg=7f ft=0", an, seg, frame_tick);
      end
    end else begin
      resetn = rn;
    end
    en = e; raw_segs = raw; blank_mask = bl; blink_mask = bk;
    x = '{an: {ND{1'b1}}, seg: 7'h7F, ft: 1'b0};
    if (!rn) begin
      m_n = 0;
      m_nib = 4'h0;
    end else if (e) begin
      p    = m_n % SD;
      slot = m_n / SD;
      idx  = slot % ND;
      bp   = ((slot / ND) / BF) % 2;
      if (p == 0) m_nib = raw[idx*4 +: 4];
      else if (!bl[idx] && !(bk[idx] && bp == 1)) begin
        x.an  = ~(6'b000001 << idx);
        x.seg = dec[m_nib];
      end
      x.ft = ((m_n + 1) % (SD * ND)) == 0;
      m_n++;
    end
    q.push_back(x);
    mon_on = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: DUT output with no expected entry");
      end else begin
        m_x = q.pop_front();
        if (an !== m_x.an || seg !== m_x.seg || frame_tick !== m_x.ft) begin
          errors++;
          $display("FAIL scan_out @%0t: an=%b seg=%h ft=%b, want an=%b seg=%h ft=%b",
                   $time, an, seg, frame_tick, m_x.an, m_x.seg, m_x.ft);
        end
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL an_onehot0: an=%b", an);
      end
    end
  end

  initial begin
    logic [4*ND-1:0] r_raw;
    logic [ND-1:0]   r_bl, r_bk;
    logic            r_en, r_rn;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h123456, '0, '0);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 24'h123456, '0, '0);
    for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 24'h235959, '0, '0);
    for (int i = 0; i < 400; i++) step(1'b1, 1'b1, 24'h235959, '0, 6'b000011);
    step(1'b1, 1'b0, 24'h235959, '0, '0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, (i < 6) ? 24'h000000 : 24'h999999, '0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 24'hAAAAAA, '0, '0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 24'hAAAAAA, '0, '0);
    r_raw = 24'h012345; r_bl = '0; r_bk = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) r_raw = 24'($urandom);
      if ($urandom_range(0, 40) == 0) r_bl = ND'($urandom) & ND'($urandom);
      if ($urandom_range(0, 40) == 0) r_bk = ND'($urandom);
      r_en = ($urandom_range(0, 9) != 0);
      r_rn = ($urandom_range(0, 299) != 0);
      step(r_en, r_rn, r_raw, r_bl, r_bk);
    end
    @(posedge clk);
    #2;
    mon_on = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
